// File: rtl/data_mem_sequencer_pkg.sv
// Shared types for the memory-stage sequencer: size codes, FSM states, latched access.
// No logic; functions here are purely combinational. No flow control.
// Big-endian lanes throughout: offset 0 is the most significant byte.
package data_mem_sequencer_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_DONE
    } state_t;

    // Only the store lane is kept; the full store word goes straight to the write register.
    typedef struct packed {
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        logic [15:0] wlane;
    } acc_t;

    function automatic logic access_fault(input logic re, input logic we,
                                          input logic [1:0] size, input logic [1:0] off);
        return (re && we) || (size == SZ_ILLEGAL) ||
               (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/data_mem_sequencer_if.sv
// Core-side request/result and memory-side req/ack signals of the sequencer.
// No latency of its own. The memory stalls the sequencer by withholding i_Mem_Ack.
// master = sequencer view, slave = pipeline/memory environment view.
interface data_mem_sequencer_if;

    logic        i_Re;
    logic        i_We;
    logic [1:0]  i_Size;
    logic        i_Signed;
    logic [31:0] i_Addr;
    logic [31:0] i_Wdata;
    logic        o_Stall;
    logic [31:0] o_Rdata;
    logic        o_Rvalid;
    logic        o_Fault;
    logic        o_Mem_Req;
    logic        o_Mem_We;
    logic [31:0] o_Mem_Addr;
    logic [31:0] o_Mem_Wdata;
    logic        i_Mem_Ack;
    logic [31:0] i_Mem_Rdata;

    modport master (
        input  i_Re, i_We, i_Size, i_Signed, i_Addr, i_Wdata, i_Mem_Ack, i_Mem_Rdata,
        output o_Stall, o_Rdata, o_Rvalid, o_Fault, o_Mem_Req, o_Mem_We, o_Mem_Addr, o_Mem_Wdata
    );

    modport slave (
        output i_Re, i_We, i_Size, i_Signed, i_Addr, i_Wdata, i_Mem_Ack, i_Mem_Rdata,
        input  o_Stall, o_Rdata, o_Rvalid, o_Fault, o_Mem_Req, o_Mem_We, o_Mem_Addr, o_Mem_Wdata
    );

endinterface

// File: rtl/data_mem_sequencer_lane_align.sv
// Big-endian lane extraction/extension for loads and lane merge for sub-word stores.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs.
module data_mem_sequencer_lane_align
    import data_mem_sequencer_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  off,
    input  logic [31:0] rd_word,
    input  logic [15:0] wr_lane,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rd_word[31:24];
        case (off)
            2'd0:    byte_lane = rd_word[31:24];
            2'd1:    byte_lane = rd_word[23:16];
            2'd2:    byte_lane = rd_word[15:8];
            default: byte_lane = rd_word[7:0];
        endcase
        half_lane = off[1] ? rd_word[15:0] : rd_word[31:16];

        ld_data = rd_word;
        st_word = rd_word;
        case (size)
            SZ_BYTE: begin
                ld_data = {{24{sgn & byte_lane[7]}}, byte_lane};
                case (off)
                    2'd0:    st_word[31:24] = wr_lane[7:0];
                    2'd1:    st_word[23:16] = wr_lane[7:0];
                    2'd2:    st_word[15:8]  = wr_lane[7:0];
                    default: st_word[7:0]   = wr_lane[7:0];
                endcase
            end
            SZ_HALF: begin
                ld_data = {{16{sgn & half_lane[15]}}, half_lane};
                if (off[1]) st_word[15:0]  = wr_lane;
                else        st_word[31:16] = wr_lane;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_sequencer.sv
// Memory-stage sequencer: one load/store per instruction, sb/sh done as read-modify-write.
// Zero-wait memory: loads/sw finish in 3 cycles, sb/sh in 4, faults in 2; each ack wait adds one.
// Stalls the pipeline until DONE; memory backpressure is i_Mem_Ack, one request outstanding.
module data_mem_sequencer
    import data_mem_sequencer_pkg::*;
(
    input  logic                 i_Clk,
    input  logic                 i_Reset_n,
    data_mem_sequencer_if.master bus
);

    state_t      state_q, state_d;
    acc_t        acc_q;
    logic        stall;
    logic        req_present;
    logic        fault_in;
    logic        accept;
    logic        mem_req_q, mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [31:0] rdata_q;
    logic        rvalid_q, fault_q;
    logic [31:0] ld_data, st_word;

    assign req_present = bus.i_Re | bus.i_We;
    assign fault_in    = access_fault(bus.i_Re, bus.i_We, bus.i_Size, bus.i_Addr[1:0]);
    assign accept      = (state_q == ST_IDLE) && req_present;

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_present) begin
                    stall = 1'b1;
                    if (fault_in)               state_d = ST_DONE;
                    else if (bus.i_Re)          state_d = ST_READ;
                    else if (bus.i_Size == SZ_WORD) state_d = ST_WRITE;
                    else                        state_d = ST_RMW_RD;
                end
            end
            ST_READ, ST_WRITE: begin
                stall = 1'b1;
                if (bus.i_Mem_Ack) state_d = ST_DONE;
            end
            ST_RMW_RD: begin
                stall = 1'b1;
                if (bus.i_Mem_Ack) state_d = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                stall = 1'b1;
                if (bus.i_Mem_Ack) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    data_mem_sequencer_lane_align u_lane_align (
        .size    (acc_q.size),
        .sgn     (acc_q.sgn),
        .off     (acc_q.off),
        .rd_word (bus.i_Mem_Rdata),
        .wr_lane (acc_q.wlane),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    // Memory controls are decoded from the next state so they are registered
    // and only change on the ack edge (or on entry from IDLE).
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= state_d inside {ST_READ, ST_WRITE, ST_RMW_RD, ST_RMW_WR};
            mem_we_q  <= state_d inside {ST_WRITE, ST_RMW_WR};
            rvalid_q  <= (state_q == ST_READ) && bus.i_Mem_Ack;
            fault_q   <= accept && fault_in;
            if (accept) begin
                acc_q.size  <= bus.i_Size;
                acc_q.sgn   <= bus.i_Signed;
                acc_q.off   <= bus.i_Addr[1:0];
                acc_q.wlane <= bus.i_Wdata[15:0];
                if (fault_in) begin
                    rdata_q <= '0;
                end else begin
                    mem_addr_q <= {bus.i_Addr[31:2], 2'b00};
                    if (bus.i_We) mem_wdata_q <= bus.i_Wdata;
                end
            end
            if ((state_q == ST_READ) && bus.i_Mem_Ack)   rdata_q     <= ld_data;
            if ((state_q == ST_RMW_RD) && bus.i_Mem_Ack) mem_wdata_q <= st_word;
        end
    end

    assign bus.o_Stall     = stall;
    assign bus.o_Rdata     = rdata_q;
    assign bus.o_Rvalid    = rvalid_q;
    assign bus.o_Fault     = fault_q;
    assign bus.o_Mem_Req   = mem_req_q;
    assign bus.o_Mem_We    = mem_we_q;
    assign bus.o_Mem_Addr  = mem_addr_q;
    assign bus.o_Mem_Wdata = mem_wdata_q;

endmodule
